fpu_req_arbiter: RTL
====================

FPU_REQ_ARBITER -- requirements
Module: fpu_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort (range 2..255).
REQ-003 SHALL have a single clock and an asynchronous active-low reset: port ACLK is the clock, port ARESETN the reset.
REQ-004 ACLK  in  1  clock; all state on rising edge.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 sN_req_valid / sN_req_ready (N=0,1)  in / out  1  requester-N command handshake.
REQ-007 sN_opcode  in  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 sN_op_a, sN_op_b  in  DATA_W  IEEE-754 operands.
REQ-009 sN_rsp_valid / sN_rsp_ready  out / in  1  requester-N response handshake.
REQ-010 sN_rsp_data  out  DATA_W  result.
REQ-011 sN_rsp_status  out  2  00 OK, 01 FPU exception, 10 timeout.
REQ-012 fpu_start  out  1  one-cycle start pulse to shared FPU core.
REQ-013 fpu_opcode, fpu_op_a, fpu_op_b  out  2/DATA_W/DATA_W  registered command to core.
REQ-014 fpu_done  in  1  core completion pulse; fpu_result  in  DATA_W; fpu_flags  in  4  {invalid, divzero, overflow, underflow}.
REQ-015 busy  out  1  high whenever state != IDLE; grant_id  out  1  requester currently owning the core.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: sN_req_ready SHALL be high only for the granted requester; accept on valid&&ready, latch opcode/operands/grant_id, go ISSUE.
REQ-018 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last-grant pointer resets to 1 (s0 wins first tie).
REQ-019 ISSUE: fpu_start high exactly one cycle, then WAIT.
REQ-020 WAIT: on fpu_done capture fpu_result; status 01 if any fpu_flags bit set, else 00; go RESP.
REQ-021 RESP: rsp_valid high on granted requester only; data/status stable until rsp_ready; on handshake go IDLE.
REQ-022 Latency: accept at cycle T -> fpu_start at T+1 -> done at T+1+L -> rsp_valid at T+2+L.
REQ-023 fpu_done outside WAIT SHALL be ignored; fpu_done coincident with timeout expiry SHALL win (status by flags).
REQ-024 No new request accepted while busy; requests held valid remain pending without loss.
REQ-025 Non-granted sN_rsp_valid SHALL stay low.

Reset
REQ-026 ARESETN low SHALL force IDLE, all ready/valid/fpu_start low, data/status/grant_id/fpu_* outputs 0, pointer 1, timeout counter 0.
REQ-027 Reset mid-operation SHALL abort without response; a later fpu_done SHALL be ignored.

Configuration
REQ-028 FPU_ARB_TIMEOUT_EN defined: WAIT counter runs; at TIMEOUT_CYCLES without fpu_done -> RESP, status 10, data 0x7FC00000.
REQ-029 FPU_ARB_TIMEOUT_EN undefined: no counter; WAIT left only by fpu_done; status 10 never produced.

Structure
REQ-030 Package fpu_arb_pkg SHALL hold state enum, opcode enum, status constants, QNAN constant.
REQ-031 Sub-module fpu_rr_arb (2-way round-robin grant with pointer) SHALL be used; rest in top.

Verification
REQ-032 s0 add 0x3F800000+0x40000000, core L=3 -> fpu_start at T+1, s0_rsp_data 0x40400000, status 00 at T+5.
REQ-033 s0,s1 valid same cycle after reset -> s0 served first, then s1; next tie -> s0 again only if s1 served last.
REQ-034 s1 div by 0x00000000, core flags=0100 -> s1_rsp_status 01, s0_rsp_valid never high.
REQ-035 With FPU_ARB_TIMEOUT_EN, no fpu_done -> status 10, data 0x7FC00000 after 64 WAIT cycles; stray done afterward ignored.
REQ-036 rsp_ready held low 10 cycles -> rsp_valid/data stable, s1 pending request stalls until handshake.
REQ-037 ARESETN low during WAIT -> all outputs reset, no response, late fpu_done ignored.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the two-requester FPU arbiter.
package fpu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } fpu_op_t;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_FPU_EXC = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_rr_arb.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester.
module fpu_rr_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic grant_valid,
   output logic grant_id
);

   logic last_grant;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_valid = req0 | req1;
      grant_id    = 1'b0;
      if (req0 && req1) begin
         grant_id = ~last_grant;
      end else if (req1) begin
         grant_id = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU core between two requesters (IDLE/ISSUE/WAIT/RESP sequencing).
// Optional WAIT timeout abort is compiled in with `define FPU_ARB_TIMEOUT_EN.
module fpu_req_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              s0_req_valid,
   output logic              s0_req_ready,
   input  logic [1:0]        s0_opcode,
   input  logic [DATA_W-1:0] s0_op_a,
   input  logic [DATA_W-1:0] s0_op_b,
   output logic              s0_rsp_valid,
   input  logic              s0_rsp_ready,
   output logic [DATA_W-1:0] s0_rsp_data,
   output logic [1:0]        s0_rsp_status,
   input  logic              s1_req_valid,
   output logic              s1_req_ready,
   input  logic [1:0]        s1_opcode,
   input  logic [DATA_W-1:0] s1_op_a,
   input  logic [DATA_W-1:0] s1_op_b,
   output logic              s1_rsp_valid,
   input  logic              s1_rsp_ready,
   output logic [DATA_W-1:0] s1_rsp_data,
   output logic [1:0]        s1_rsp_status,
   output logic              fpu_start,
   output logic [1:0]        fpu_opcode,
   output logic [DATA_W-1:0] fpu_op_a,
   output logic [DATA_W-1:0] fpu_op_b,
   input  logic              fpu_done,
   input  logic [DATA_W-1:0] fpu_result,
   input  logic [3:0]        fpu_flags,
   output logic              busy,
   output logic              grant_id
);

   arb_state_t        state, next_state;
   logic              arb_valid, arb_id;
   logic              accept, rsp_hs, timeout_hit;
   logic              grant_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        rsp_status_q;

   fpu_rr_arb u_rr_arb (
      .clk         (ACLK),
      .rst_n       (ARESETN),
      .req0        (s0_req_valid),
      .req1        (s1_req_valid),
      .accept      (accept),
      .grant_valid (arb_valid),
      .grant_id    (arb_id)
   );

   // Ready is held low while reset is asserted even though IDLE is forced.
   assign s0_req_ready = ARESETN && (state == IDLE) && arb_valid && !arb_id;
   assign s1_req_ready = ARESETN && (state == IDLE) && arb_valid &&  arb_id;
   assign accept       = (s0_req_valid && s0_req_ready) || (s1_req_valid && s1_req_ready);
   assign rsp_hs       = (state == RESP) && (grant_q ? s1_rsp_ready : s0_rsp_ready);

   assign fpu_start     = (state == ISSUE);
   assign busy          = (state != IDLE);
   assign grant_id      = grant_q;
   assign s0_rsp_valid  = (state == RESP) && !grant_q;
   assign s1_rsp_valid  = (state == RESP) &&  grant_q;
   assign s0_rsp_data   = rsp_data_q;
   assign s1_rsp_data   = rsp_data_q;
   assign s0_rsp_status = rsp_status_q;
   assign s1_rsp_status = rsp_status_q;

`ifdef FPU_ARB_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // Counts completed WAIT cycles; cleared whenever the FSM is elsewhere.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wait_cnt <= '0;
      end else if (state == WAIT) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   assign timeout_hit = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   // WAIT is left only by fpu_done; the expression is constant false.
   assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // fpu_done is checked before the timeout so a coincident completion wins.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = ISSUE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (fpu_done || timeout_hit) next_state = RESP;
         RESP:    if (rsp_hs) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         grant_q      <= 1'b0;
         fpu_opcode   <= '0;
         fpu_op_a     <= '0;
         fpu_op_b     <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= STATUS_OK;
      end else begin
         if (accept) begin
            grant_q    <= arb_id;
            fpu_opcode <= arb_id ? s1_opcode : s0_opcode;
            fpu_op_a   <= arb_id ? s1_op_a   : s0_op_a;
            fpu_op_b   <= arb_id ? s1_op_b   : s0_op_b;
         end
         if (state == WAIT) begin
            if (fpu_done) begin
               rsp_data_q   <= fpu_result;
               rsp_status_q <= (|fpu_flags) ? STATUS_FPU_EXC : STATUS_OK;
            end else if (timeout_hit) begin
               rsp_data_q   <= DATA_W'(QNAN);
               rsp_status_q <= STATUS_TIMEOUT;
            end
         end
      end
   end

endmodule
